tiny_program_loader: RTL
========================

// Module: tiny_program_loader
// PURPOSE
//  Writer side of the tiny processor's 16x8 program memory: receives a program over UART (8N1), writes it
//  into a 16-entry instruction RAM, verifies a checksum, then releases the processor from reset.
//  The processor fetches instructions through the asynchronous read port (fetch_addr -> fetch_data).
// PARAMETERS
//  CLKS_PER_BIT  868   clock cycles per UART bit (100 MHz / 115200); must be >= 4
//  SYNC_BYTE     8'hA5 header byte that opens a load frame
// PORTS
//  clock         in   1  system clock, all logic on rising edge
//  reset_p       in   1  asynchronous, active-high reset
//  uart_rx       in   1  serial input, idle high, asynchronous to clock
//  load_req      in   1  1-cycle pulse: arm a new load
//  fetch_addr    in   4  processor PC
//  fetch_data    out  8  {INST,IMM} = ram[fetch_addr], combinational
//  cpu_reset_p   out  1  active-high reset to processor
//  busy          out  1  load in progress (WAIT_SYNC/LOAD/CHECK)
//  done          out  1  last load verified OK (level)
//  error         out  1  last load failed: checksum or framing (level)
//  bytes_loaded  out  5  program bytes written in current/last load, 0..16
// BEHAVIOUR
//  Reset: all 16 RAM entries = 8'h00, cpu_reset_p=1, busy=0, done=0, error=0, bytes_loaded=0, FSM=IDLE,
//   UART RX idle. Processor is held in reset until the first successful load.
//  UART RX: uart_rx passes 2-flop synchroniser (reset value 1). Falling edge in RX idle starts a byte;
//   sample at CLKS_PER_BIT/2 -> must still be 0, else drop silently and return to RX idle.
//   Then 8 data bits LSB first, each sampled CLKS_PER_BIT later; stop bit sampled likewise.
//   Stop=1 -> 1-cycle byte_valid with rx_byte. Stop=0 -> 1-cycle frame_err, no byte_valid.
//   RX returns to idle after the stop sample; next start bit accepted immediately.
//  Frame format: SYNC_BYTE, 16 program bytes (addr 0..15), checksum = 8-bit sum mod 256 of the 16 bytes.
//  FSM:
//   IDLE: load_req -> WAIT_SYNC. Received bytes ignored.
//   WAIT_SYNC: cpu_reset_p=1, busy=1, done=0, error=0, bytes_loaded=0, sum=0.
//     byte==SYNC_BYTE -> LOAD; any other byte ignored.
//   LOAD: each byte_valid: ram[bytes_loaded[3:0]]<=byte, sum<=sum+byte, bytes_loaded++.
//     Write is visible on fetch_data the cycle after byte_valid. On the 16th byte -> CHECK.
//   CHECK: next byte_valid: byte==sum -> DONE, else -> ERROR.
//   DONE: done=1, busy=0, cpu_reset_p=0 from the first cycle in DONE (1 cycle after checksum byte_valid).
//   ERROR: error=1, busy=0, cpu_reset_p=1. RAM keeps partial contents.
//  frame_err in WAIT_SYNC/LOAD/CHECK -> ERROR; ignored in IDLE/DONE/ERROR.
//  load_req in any state (incl. busy states) -> WAIT_SYNC next cycle: counters/sum cleared, cpu_reset_p=1.
//   load_req coinciding with byte_valid: load_req wins, the byte is discarded.
//  Bytes received in DONE/ERROR are ignored; RAM is written only in LOAD.
//  bytes_loaded saturates at 16; the address wraps never (16 writes max per frame).
//  reset_p mid-load: everything returns to reset values immediately, incl. RAM.
//  fetch_data valid in every state; processor fetches are never blocked (it is in reset while loading).
// TESTING (CLKS_PER_BIT=8 for sim)
//  1 After reset: fetch_data=8'h00 for all addrs, cpu_reset_p=1, done=0, error=0.
//  2 load_req; send A5,81,82,84,88,84,82,A0,00 x9,B5 -> done=1, cpu_reset_p=0, fetch_addr=6 gives A0.
//  3 Same frame with checksum B4 -> error=1, cpu_reset_p=1, bytes_loaded=16, done=0.
//  4 Send 3C,A5 before frame in WAIT_SYNC -> 3C ignored, load completes, ram[0]=81.
//  5 Stop bit=0 on 5th program byte -> error=1, bytes_loaded=4; reload with good frame -> done=1.
//  6 load_req after 8 program bytes -> busy=1, bytes_loaded=0; full new frame loads OK, done=1.

Source files
------------

// File: rtl/tiny_program_loader.sv
`default_nettype none
// ============================================================================
// Module  : tiny_program_loader
// Purpose : UART-fed writer for a 16x8 instruction RAM. It checks the frame
//           checksum and then releases the processor from reset.
// Rev     : 1.0  initial release
// ============================================================================
module tiny_program_loader #(
    parameter int         CLKS_PER_BIT = 868,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
    input  logic       clock,
    input  logic       reset_p,
    input  logic       uart_rx,
    input  logic       load_req,
    input  logic [3:0] fetch_addr,
    output logic [7:0] fetch_data,
    output logic       cpu_reset_p,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [4:0] bytes_loaded
);

    localparam int                 c_cnt_w   = $clog2(CLKS_PER_BIT);
    localparam logic [c_cnt_w-1:0] c_half    = c_cnt_w'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_cnt_w-1:0] c_full    = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {ST_IDLE, ST_WAIT_SYNC, ST_LOAD, ST_CHECK, ST_DONE, ST_ERROR} state_t;

    rx_state_t          r_rx_state;
    logic               r_rx_meta;
    logic               r_rx_sync;
    logic               r_rx_prev;
    logic [c_cnt_w-1:0] r_rx_cnt;
    logic [2:0]         r_rx_bit;
    logic [7:0]         r_rx_shift;
    logic [7:0]         r_rx_byte;
    logic               r_byte_valid;
    logic               r_frame_err;

    state_t             r_state;
    logic [7:0]         r_sum;
    logic [7:0]         r_ram [16];

    // Receiver: start bit re-checked mid-bit, later bits sampled one bit period apart.
    always_ff @(posedge clock or posedge reset_p) begin
        if (reset_p) begin
            r_rx_meta    <= 1'b1;
            r_rx_sync    <= 1'b1;
            r_rx_prev    <= 1'b1;
            r_rx_state   <= RX_IDLE;
            r_rx_cnt     <= '0;
            r_rx_bit     <= '0;
            r_rx_shift   <= '0;
            r_rx_byte    <= '0;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_rx_meta    <= uart_rx;
            r_rx_sync    <= r_rx_meta;
            r_rx_prev    <= r_rx_sync;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            case (r_rx_state)
                RX_IDLE: begin
                    if (r_rx_prev && !r_rx_sync) begin
                        r_rx_state <= RX_START;
                        r_rx_cnt   <= '0;
                    end
                end
                RX_START: begin
                    if (r_rx_cnt == c_half) begin
                        r_rx_cnt   <= '0;
                        r_rx_bit   <= '0;
                        r_rx_state <= r_rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + c_cnt_one;
                    end
                end
                RX_DATA: begin
                    if (r_rx_cnt == c_full) begin
                        r_rx_cnt   <= '0;
                        r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
                        r_rx_bit   <= r_rx_bit + 3'd1;
                        if (r_rx_bit == 3'd7) begin
                            r_rx_state <= RX_STOP;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + c_cnt_one;
                    end
                end
                RX_STOP: begin
                    if (r_rx_cnt == c_full) begin
                        r_rx_cnt   <= '0;
                        r_rx_state <= RX_IDLE;
                        if (r_rx_sync) begin
                            r_byte_valid <= 1'b1;
                            r_rx_byte    <= r_rx_shift;
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + c_cnt_one;
                    end
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

    // Load sequencer; load_req outranks everything, including a byte arriving that cycle.
    always_ff @(posedge clock or posedge reset_p) begin
        if (reset_p) begin
            r_state      <= ST_IDLE;
            r_sum        <= '0;
            cpu_reset_p  <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            bytes_loaded <= '0;
            for (int i = 0; i < 16; i++) begin
                r_ram[i] <= '0;
            end
        end else if (load_req) begin
            r_state      <= ST_WAIT_SYNC;
            r_sum        <= '0;
            cpu_reset_p  <= 1'b1;
            busy         <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            bytes_loaded <= '0;
        end else if (r_frame_err && busy) begin
            r_state     <= ST_ERROR;
            cpu_reset_p <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b1;
        end else if (r_byte_valid) begin
            case (r_state)
                ST_WAIT_SYNC: begin
                    if (r_rx_byte == SYNC_BYTE) begin
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_ram[bytes_loaded[3:0]] <= r_rx_byte;
                    r_sum                    <= r_sum + r_rx_byte;
                    bytes_loaded             <= bytes_loaded + 5'd1;
                    if (bytes_loaded == 5'd15) begin
                        r_state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    busy <= 1'b0;
                    if (r_rx_byte == r_sum) begin
                        r_state     <= ST_DONE;
                        done        <= 1'b1;
                        cpu_reset_p <= 1'b0;
                    end else begin
                        r_state <= ST_ERROR;
                        error   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign fetch_data = r_ram[fetch_addr];

endmodule
`default_nettype wire
